sync_fifo_flags: RTL and testbench

Single-clock, parametrised successor to the team's dual-clock FIFO, for buffering SL transceiver words inside one clock domain.
Adds the following over the dual-clock block: a fill-level output, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, synchronous flush, and a selectable read mode (first-word-fall-through or registered).
Pointers are binary; no Gray coding or synchroniser stages are needed.

---
 rtl/sync_fifo_flags.sv | 131 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, sticky error flags,
// synchronous flush and a selectable first-word-fall-through or registered read port.
module sync_fifo_flags #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter bit          FWFT      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 wr_inc,
  output logic                 wr_full,
  input  logic                 rd_inc,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_empty,
  input  logic                 flush,
  input  logic [ADDR_SIZE:0]   af_thresh,
  input  logic [ADDR_SIZE:0]   ae_thresh,
  output logic [ADDR_SIZE:0]   level,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int unsigned        Depth     = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] LevelFull = (ADDR_SIZE + 1)'(Depth);
  localparam logic [ADDR_SIZE:0] One       = (ADDR_SIZE + 1)'(1);

  logic [DATA_SIZE-1:0] mem_q [Depth];

  logic [ADDR_SIZE:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0] level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic                 wa, ra;
  logic                 ov_set, un_set;
  logic [ADDR_SIZE-1:0] wr_idx, rd_idx;

  // Pointer MSBs only exist so the pointers wrap at 2*Depth; the level register
  // carries the full/empty distinction instead.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wr_ptr_q[ADDR_SIZE] ^ rd_ptr_q[ADDR_SIZE];

  assign wr_idx = wr_ptr_q[ADDR_SIZE-1:0];
  assign rd_idx = rd_ptr_q[ADDR_SIZE-1:0];

  assign rd_empty     = (level_q == '0);
  assign wr_full      = (level_q == LevelFull);
  assign level        = level_q;
  assign almost_full  = (level_q >= af_thresh);
  assign almost_empty = (level_q <= ae_thresh);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wa     = wr_inc & ~wr_full & ~flush;
  assign ra     = rd_inc & ~rd_empty & ~flush;
  assign ov_set = wr_inc & wr_full & ~flush;
  assign un_set = rd_inc & rd_empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wa) wr_ptr_d = wr_ptr_q + One;
      if (ra) rd_ptr_d = rd_ptr_q + One;
      unique case ({wa, ra})
        2'b10:   level_d = level_q + One;
        2'b01:   level_d = level_q - One;
        default: level_d = level_q;
      endcase
    end

    // A same-cycle set beats clr_err so no error event is ever lost.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ov_set) overflow_d  = 1'b1;
    if (un_set) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; only the write gate honours rst.
  always_ff @(posedge clk) begin
    if (wa && !rst) mem_q[wr_idx] <= wr_data;
  end

  if (FWFT) begin : g_fwft
    assign rd_data = mem_q[rd_idx];
  end else begin : g_reg
    logic [DATA_SIZE-1:0] rd_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
      end else if (ra) begin
        rd_data_q <= mem_q[rd_idx];
      end
    end

    assign rd_data = rd_data_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a first-word-fall-through and a registered-read instance with identical stimulus
// and checks both against a queue-based model plus a table of hand-derived vectors.
module tb_sync_fifo_flags;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       rst, wr_inc, rd_inc, flush, clr_err;
  logic [7:0] wr_data;
  logic [4:0] af_thresh, ae_thresh;

  logic [7:0] rd_data_f, rd_data_r;
  logic [4:0] level_f, level_r;
  logic       full_f, full_r, empty_f, empty_r;
  logic       af_f, af_r, ae_f, ae_r, ov_f, ov_r, un_f, un_r;

  sync_fifo_flags #(.ADDR_SIZE(4), .DATA_SIZE(8), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .wr_full(full_f),
    .rd_inc(rd_inc), .rd_data(rd_data_f), .rd_empty(empty_f), .flush(flush),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level_f),
    .almost_full(af_f), .almost_empty(ae_f), .overflow(ov_f), .underflow(un_f),
    .clr_err(clr_err)
  );

  sync_fifo_flags #(.ADDR_SIZE(4), .DATA_SIZE(8), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .wr_full(full_r),
    .rd_inc(rd_inc), .rd_data(rd_data_r), .rd_empty(empty_r), .flush(flush),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .level(level_r),
    .almost_full(af_r), .almost_empty(ae_r), .overflow(ov_r), .underflow(un_r),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents as a queue, flags and registered read word as scalars.
  logic [7:0] q[$];
  logic       m_ov, m_un;
  logic [7:0] m_rreg;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit full, empty, set_ov, set_un;
    if (rst) begin
      q.delete();
      m_ov   = 1'b0;
      m_un   = 1'b0;
      m_rreg = 8'h00;
    end else begin
      full   = (q.size() == Depth);
      empty  = (q.size() == 0);
      set_ov = wr_inc && full && !flush;
      set_un = rd_inc && empty && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (rd_inc && !empty) m_rreg = q.pop_front();
        if (wr_inc && !full) q.push_back(wr_data);
      end
      m_ov = set_ov ? 1'b1 : (clr_err ? 1'b0 : m_ov);
      m_un = set_un ? 1'b1 : (clr_err ? 1'b0 : m_un);
    end
  endtask

  task automatic check_model(input string tag);
    int lvl;
    lvl = q.size();
    cmp({tag, " level_f"}, 32'(level_f), 32'(lvl));
    cmp({tag, " level_r"}, 32'(level_r), 32'(lvl));
    cmp({tag, " empty"}, {30'd0, empty_f, empty_r}, {30'd0, lvl == 0, lvl == 0});
    cmp({tag, " full"}, {30'd0, full_f, full_r}, {30'd0, lvl == Depth, lvl == Depth});
    cmp({tag, " almost_full"}, {30'd0, af_f, af_r},
        {30'd0, lvl >= int'(af_thresh), lvl >= int'(af_thresh)});
    cmp({tag, " almost_empty"}, {30'd0, ae_f, ae_r},
        {30'd0, lvl <= int'(ae_thresh), lvl <= int'(ae_thresh)});
    cmp({tag, " overflow"}, {30'd0, ov_f, ov_r}, {30'd0, m_ov, m_ov});
    cmp({tag, " underflow"}, {30'd0, un_f, un_r}, {30'd0, m_un, m_un});
    if (lvl > 0) cmp({tag, " fwft head"}, 32'(rd_data_f), 32'(q[0]));
    cmp({tag, " reg rd_data"}, 32'(rd_data_r), 32'(m_rreg));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    rst     = 1'b0;
    wr_inc  = 1'b0;
    rd_inc  = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  typedef struct {
    logic       rst, wr, rd, flush, clr;
    logic [7:0] data;
    int         lvl;
    logic       ov, un;
    logic [7:0] head, rreg;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic f,
                              input logic c, input logic [7:0] d, input int lvl,
                              input logic ov, input logic un, input logic [7:0] head,
                              input logic [7:0] rreg);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.flush = f; v.clr = c; v.data = d;
    v.lvl = lvl; v.ov = ov; v.un = un; v.head = head; v.rreg = rreg;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    //            rst wr rd fl clr data  lvl ov un head   rreg
    tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    tbl[1]  = mk(0, 1, 1, 0, 0, 8'hAA, 1, 0, 1, 8'hAA, 8'h00);  // empty: read rejected
    tbl[2]  = mk(0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 8'hAA, 8'h00);
    tbl[3]  = mk(0, 1, 0, 0, 0, 8'hBB, 2, 0, 0, 8'hAA, 8'h00);
    tbl[4]  = mk(0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 8'hBB, 8'hAA);
    tbl[5]  = mk(0, 1, 1, 0, 0, 8'hCC, 1, 0, 0, 8'hCC, 8'hBB);
    tbl[6]  = mk(0, 1, 1, 1, 0, 8'hDD, 0, 0, 0, 8'h00, 8'hBB);  // flush wins
    tbl[7]  = mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'hBB);
    tbl[8]  = mk(0, 0, 1, 0, 1, 8'h00, 0, 0, 1, 8'h00, 8'hBB);  // set beats clear
    tbl[9]  = mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 8'hBB);
    tbl[10] = mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'hBB);
    tbl[11] = mk(1, 1, 1, 0, 0, 8'h11, 0, 0, 0, 8'h00, 8'h00);  // rst overrides all

    idle();
    wr_data   = 8'h00;
    af_thresh = 5'd4;
    ae_thresh = 5'd1;
    m_ov      = 1'b0;
    m_un      = 1'b0;
    m_rreg    = 8'h00;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; wr_inc = tbl[i].wr; rd_inc = tbl[i].rd;
      flush = tbl[i].flush; clr_err = tbl[i].clr; wr_data = tbl[i].data;
      tick($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d tbl level", i), 32'(level_f), 32'(tbl[i].lvl));
      cmp($sformatf("vec%0d tbl flags", i), {30'd0, ov_r, un_r}, {30'd0, tbl[i].ov, tbl[i].un});
      cmp($sformatf("vec%0d tbl empty", i), 32'(empty_r), 32'(tbl[i].lvl == 0));
      cmp($sformatf("vec%0d tbl almost_empty", i), 32'(ae_f), 32'(tbl[i].lvl <= 1));
      if (tbl[i].lvl > 0) cmp($sformatf("vec%0d tbl head", i), 32'(rd_data_f), 32'(tbl[i].head));
      cmp($sformatf("vec%0d tbl rreg", i), 32'(rd_data_r), 32'(tbl[i].rreg));
    end

    // Fill to full with thresholds, overflow with simultaneous read, then drain in order
    idle();
    af_thresh = 5'd12;
    ae_thresh = 5'd3;
    rst = 1'b1;
    tick("reset2");
    idle();
    for (int i = 1; i <= Depth; i++) begin
      wr_inc  = 1'b1;
      wr_data = 8'(i);
      tick($sformatf("fill%0d", i));
      cmp($sformatf("fill%0d level", i), 32'(level_r), 32'(i));
      cmp($sformatf("fill%0d thresholds", i), {30'd0, af_f, ae_f}, {30'd0, i >= 12, i <= 3});
    end
    cmp("full after 16 writes", {31'd0, full_f}, 32'd1);
    wr_inc  = 1'b1;
    rd_inc  = 1'b1;
    wr_data = 8'hEE;
    tick("full wr+rd");
    cmp("full wr+rd level", 32'(level_f), 32'd15);
    cmp("full wr+rd overflow", 32'(ov_r), 32'd1);
    cmp("full wr+rd rreg", 32'(rd_data_r), 32'h01);
    idle();
    clr_err = 1'b1;
    tick("clr overflow");
    cmp("clr overflow", 32'(ov_f), 32'd0);
    idle();
    for (int k = 2; k <= Depth; k++) begin
      rd_inc = 1'b1;
      tick($sformatf("drain%0d", k));
      cmp($sformatf("drain%0d rreg", k), 32'(rd_data_r), 32'(k));
      cmp($sformatf("drain%0d thresholds", k), {30'd0, af_f, ae_f},
          {30'd0, (Depth - k) >= 12, (Depth - k) <= 3});
    end
    cmp("drained empty", {31'd0, empty_f}, 32'd1);
    cmp("drained level", 32'(level_f), 32'd0);

    // Flush at level 9 with same-cycle requests, then reuse
    idle();
    for (int i = 0; i < 9; i++) begin
      wr_inc  = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick("pre-flush fill");
    end
    cmp("pre-flush level", 32'(level_f), 32'd9);
    wr_inc = 1'b1;
    rd_inc = 1'b1;
    flush  = 1'b1;
    tick("flush");
    cmp("flush level", 32'(level_r), 32'd0);
    cmp("flush errors", {30'd0, ov_f, un_f}, 32'd0);
    idle();
    wr_inc  = 1'b1;
    wr_data = 8'h55;
    tick("post-flush write");
    cmp("post-flush fwft", 32'(rd_data_f), 32'h55);
    idle();
    rd_inc = 1'b1;
    tick("post-flush read");
    cmp("post-flush rreg", 32'(rd_data_r), 32'h55);

    // Randomized traffic across many pointer wraps
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        af_thresh = 5'($urandom_range(0, 18));
        ae_thresh = 5'($urandom_range(0, 18));
      end
      rst     = 1'b0;
      wr_inc  = ($urandom_range(0, 99) < 55);
      rd_inc  = ($urandom_range(0, 99) < 50);
      flush   = ($urandom_range(0, 99) < 2);
      clr_err = ($urandom_range(0, 99) < 5);
      wr_data = 8'($urandom);
      tick($sformatf("rand%0d", c));
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
